// File: rtl/sif_responder_if.sv
// SIF X-bus access port and W write-port grouped into one bundle.
// slave = responder side, master = X driver / W consumer side.
interface sif_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              xa_wr_s;
    logic              xa_rd_s;
    logic [ADDR_W-1:0] xa_addr;
    logic [DATA_W-1:0] xa_data_wr;
    logic [DATA_W-1:0] xa_data_rd;
    logic              xa_busy;
    logic              wa_wr_s;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data_wr;
    logic              wa_ready;

    modport slave (
        input  xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_ready,
        output xa_data_rd, xa_busy, wa_wr_s, wa_addr, wa_data_wr
    );

    modport master (
        output xa_wr_s, xa_rd_s, xa_addr, xa_data_wr, wa_ready,
        input  xa_data_rd, xa_busy, wa_wr_s, wa_addr, wa_data_wr
    );
endinterface

// File: rtl/sif_responder.sv
// SIF X-bus target: register bank with registered reads, writes forwarded to the W port via a FIFO.
// Optional saturating error counter output err_cnt enabled by defining SIF_RESP_ERR_CNT_EN.
module sif_responder #(
    parameter int              ADDR_W     = 16,
    parameter int              DATA_W     = 16,
    parameter int              NUM_REGS   = 16,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] BAD_DATA = 16'hBADA
) (
    input  logic           clk,
    input  logic           rst_n,
    sif_responder_if.slave bus
`ifdef SIF_RESP_ERR_CNT_EN
    ,
    output logic [7:0]     err_cnt
`endif
);
    localparam int IDX_W = $clog2(NUM_REGS);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WORD_W = ADDR_W + DATA_W;
    localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic              in_range;
    logic              push;
    logic              pop;
    logic              wr_accept;
    logic              rd_en;
    logic [IDX_W-1:0]  addr_idx;
    logic [WORD_W-1:0] push_word;

    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_plus1;
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [WORD_W-1:0] head_reg;
    logic [WORD_W-1:0] head_next;
    logic              busy_reg;
    logic [DATA_W-1:0] rd_data_reg;
    logic [DATA_W-1:0] bank_q [NUM_REGS];

    assign in_range     = {1'b0, bus.xa_addr} < NUM_REGS_W;
    assign addr_idx     = bus.xa_addr[IDX_W-1:0];
    assign push_word    = {bus.xa_addr, bus.xa_data_wr};
    // Out-of-range writes still travel to W; only the bank update needs the range check.
    assign push         = bus.xa_wr_s && !busy_reg;
    assign wr_accept    = push && in_range;
    assign rd_en        = bus.xa_rd_s && !bus.xa_wr_s;
    assign pop          = (count_reg != '0) && bus.wa_ready;
    assign count_next   = count_reg + CNT_W'(push) - CNT_W'(pop);
    assign rd_ptr_plus1 = rd_ptr_reg + PTR_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_bank
            logic [DATA_W-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    word_reg <= '0;
                end else if (wr_accept && addr_idx == IDX_W'(gi)) begin
                    word_reg <= bus.xa_data_wr;
                end
            end
            assign bank_q[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= in_range ? bank_q[addr_idx] : BAD_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= push_word;
        end
    end

    // Registered head: next entry after a pop, or the pushed word when it lands in an empty/draining FIFO.
    always_comb begin
        head_next = head_reg;
        if (count_next != '0) begin
            if (pop) begin
                head_next = (count_reg == CNT_W'(1)) ? push_word : fifo_mem[rd_ptr_plus1];
            end else if (count_reg == '0) begin
                head_next = push_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            head_reg   <= '0;
            busy_reg   <= 1'b0;
        end else begin
            count_reg <= count_next;
            head_reg  <= head_next;
            busy_reg  <= (count_next == FULL_CNT);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_plus1;
            end
        end
    end

    assign bus.xa_data_rd = rd_data_reg;
    assign bus.xa_busy    = busy_reg;
    assign bus.wa_wr_s    = (count_reg != '0);
    assign bus.wa_addr    = head_reg[WORD_W-1:DATA_W];
    assign bus.wa_data_wr = head_reg[DATA_W-1:0];

`ifdef SIF_RESP_ERR_CNT_EN
    logic       err_event;
    logic [7:0] err_cnt_reg;

    assign err_event = (bus.xa_wr_s && busy_reg)
                     || (bus.xa_wr_s && bus.xa_rd_s)
                     || ((bus.xa_wr_s || bus.xa_rd_s) && !in_range);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else if (err_event && err_cnt_reg != 8'hFF) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif
endmodule

// File: tb/tb_sif_responder.sv
// Bench for sif_responder: queue/array reference model compared every cycle, plus directed literal checks.
// Covers err_cnt when SIF_RESP_ERR_CNT_EN is defined.
module tb_sif_responder;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int NR = 16;
    localparam int FD = 4;
    localparam logic [15:0] BAD = 16'hBADA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sif_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SIF_RESP_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    sif_responder #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .FIFO_DEPTH(FD), .BAD_DATA(BAD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef SIF_RESP_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: bank array, FIFO as a queue of {addr,data}, last read value, last W head.
    logic [15:0] m_bank [NR];
    logic [31:0] m_q [$];
    logic [15:0] m_rd;
    logic [31:0] m_last;
    int          m_err;
    bit          m_valid = 0;
    bit          m_busy_now;
    bit          m_inr;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NR; i++) m_bank[i] = '0;
            m_q.delete();
            m_rd = '0;
            m_last = '0;
            m_err = 0;
            m_valid = 1;
        end else begin
            m_busy_now = (m_q.size() == FD);
            m_inr = (bus.xa_addr < NR);
            if ((bus.xa_wr_s && m_busy_now) || (bus.xa_wr_s && bus.xa_rd_s)
                || ((bus.xa_wr_s || bus.xa_rd_s) && !m_inr))
                m_err = (m_err < 255) ? m_err + 1 : 255;
            if (m_q.size() != 0 && bus.wa_ready) void'(m_q.pop_front());
            if (bus.xa_wr_s) begin
                if (!m_busy_now) begin
                    if (m_inr) m_bank[bus.xa_addr[3:0]] = bus.xa_data_wr;
                    m_q.push_back({bus.xa_addr, bus.xa_data_wr});
                end
            end else if (bus.xa_rd_s) begin
                m_rd = m_inr ? m_bank[bus.xa_addr[3:0]] : BAD;
            end
        end
        if (m_q.size() != 0) m_last = m_q[0];
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("xa_data_rd", 32'(bus.xa_data_rd), 32'(m_rd));
            check("xa_busy", 32'(bus.xa_busy), 32'(m_q.size() == FD));
            check("wa_wr_s", 32'(bus.wa_wr_s), 32'(m_q.size() != 0));
            check("wa_addr", 32'(bus.wa_addr), 32'(m_last[31:16]));
            check("wa_data_wr", 32'(bus.wa_data_wr), 32'(m_last[15:0]));
`ifdef SIF_RESP_ERR_CNT_EN
            check("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op(input bit wr, input bit rd, input logic [15:0] a, input logic [15:0] d);
        bus.xa_wr_s = wr;
        bus.xa_rd_s = rd;
        bus.xa_addr = a;
        bus.xa_data_wr = d;
        tick();
        bus.xa_wr_s = 1'b0;
        bus.xa_rd_s = 1'b0;
    endtask

    initial begin
        bus.xa_wr_s = 1'b0;
        bus.xa_rd_s = 1'b0;
        bus.xa_addr = '0;
        bus.xa_data_wr = '0;
        bus.wa_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_rd", 32'(bus.xa_data_rd), 32'h0);
        check("rst_busy", 32'(bus.xa_busy), 32'h0);
        check("rst_wa_wr_s", 32'(bus.wa_wr_s), 32'h0);
        check("rst_wa_addr", 32'(bus.wa_addr), 32'h0);

        // Basic write then read
        op(1, 0, 16'd3, 16'h1234);
        check("t1_wa_wr_s", 32'(bus.wa_wr_s), 32'h1);
        check("t1_wa_addr", 32'(bus.wa_addr), 32'h3);
        check("t1_wa_data", 32'(bus.wa_data_wr), 32'h1234);
        op(0, 1, 16'd3, 16'h0);
        check("t1_rd", 32'(bus.xa_data_rd), 32'h1234);
        check("t1_model_rd", 32'(m_rd), 32'h1234);
        check("t1_wa_idle", 32'(bus.wa_wr_s), 32'h0);

        // Fill FIFO with backpressure, fifth write dropped
        bus.wa_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op(1, 0, 16'(i), 16'hA0 + 16'(i));
            if (i == 3) check("t2_busy", 32'(bus.xa_busy), 32'h1);
        end
        check("t2_model_depth", 32'(m_q.size()), 32'd4);
        bus.wa_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_addr", 32'(bus.wa_addr), 32'(i));
            check("t2_drain_data", 32'(bus.wa_data_wr), 32'hA0 + 32'(i));
            tick();
            if (i == 0) check("t2_busy_release", 32'(bus.xa_busy), 32'h0);
        end
        check("t2_empty", 32'(bus.wa_wr_s), 32'h0);
        op(0, 1, 16'd4, 16'h0);
        check("t2_dropped", 32'(bus.xa_data_rd), 32'h0);
        op(0, 1, 16'd3, 16'h0);
        check("t2_bank3", 32'(bus.xa_data_rd), 32'hA3);

        // Out-of-range accesses
        op(0, 1, 16'h0020, 16'h0);
        check("t3_bad_rd", 32'(bus.xa_data_rd), 32'hBADA);
        op(1, 0, 16'h0020, 16'h5555);
        check("t3_wa_addr", 32'(bus.wa_addr), 32'h0020);
        check("t3_wa_data", 32'(bus.wa_data_wr), 32'h5555);
        op(0, 1, 16'h0020, 16'h0);
        check("t3_bad_rd2", 32'(bus.xa_data_rd), 32'hBADA);

        // Read/write collision
        op(1, 1, 16'd7, 16'hBEEF);
        check("t4_rd_hold", 32'(bus.xa_data_rd), 32'hBADA);
        check("t4_wa_addr", 32'(bus.wa_addr), 32'h7);
        check("t4_wa_data", 32'(bus.wa_data_wr), 32'hBEEF);
        op(0, 1, 16'd7, 16'h0);
        check("t4_rd", 32'(bus.xa_data_rd), 32'hBEEF);

        // Reset mid-operation
        bus.wa_ready = 1'b0;
        op(1, 0, 16'd1, 16'h1111);
        op(1, 0, 16'd2, 16'h2222);
        check("t5_pending", 32'(bus.wa_wr_s), 32'h1);
        rst_n = 1'b0;
        tick();
        check("t5_wa_wr_s", 32'(bus.wa_wr_s), 32'h0);
        check("t5_rd", 32'(bus.xa_data_rd), 32'h0);
        check("t5_busy", 32'(bus.xa_busy), 32'h0);
        rst_n = 1'b1;
        bus.wa_ready = 1'b1;
        op(0, 1, 16'd1, 16'h0);
        check("t5_rd1", 32'(bus.xa_data_rd), 32'h0);
        op(0, 1, 16'd2, 16'h0);
        check("t5_rd2", 32'(bus.xa_data_rd), 32'h0);

`ifdef SIF_RESP_ERR_CNT_EN
        for (int i = 0; i < 300; i++) op(1, 1, 16'($urandom_range(0, 31)), 16'($urandom));
        check("t6_err_sat", 32'(err_cnt), 32'hFF);
        op(1, 1, 16'd7, 16'h0);
        tick();
        check("t6_err_hold", 32'(err_cnt), 32'hFF);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        // Randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++) begin
            bus.xa_wr_s = ($urandom_range(0, 2) == 0);
            bus.xa_rd_s = ($urandom_range(0, 2) == 0);
            bus.xa_addr = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, NR - 1));
            bus.xa_data_wr = 16'($urandom);
            bus.wa_ready = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 299) != 0);
            tick();
        end
        bus.xa_wr_s = 1'b0;
        bus.xa_rd_s = 1'b0;
        rst_n = 1'b1;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
